ingress_pkt_arbiter: RTL and testbench



---
 rtl/udp_pp_pkg.sv | 11 +
 rtl/rr_arb_pick.sv | 37 +++
 rtl/ingress_pkt_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ingress_pkt_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pp_pkg.sv
// Shared types and constants for the ingress packet arbiter slice.
package udp_pp_pkg;
    localparam int DATA_W = 256;
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        ABORT   = 2'd2
    } arb_state_t;
endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first requester strictly after i_ptr, wrapping.
module rr_arb_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant_oh,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);
    import udp_pp_pkg::*;

    always_comb begin
        int               sum;
        logic [IDX_W-1:0] w_idx;
        logic             w_found;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        sum         = 0;
        w_idx       = '0;
        for (int i = 1; i <= N; i++) begin
            sum = int'(i_ptr) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            w_idx = IDX_W'(sum);
            if (!w_found && i_req[w_idx]) begin
                w_found            = 1'b1;
                o_grant_oh[w_idx]  = 1'b1;
                o_grant_idx        = w_idx;
            end
        end
        o_any = w_found;
    end
endmodule

// File: rtl/ingress_pkt_arbiter.sv
// Packet-granular round-robin arbiter with stall watchdog in front of the header parser.
// Define ARB_STATS_EN to add per-port packet/abort counters with a registered read port.
module ingress_pkt_arbiter #(
    parameter int  NUM_PORTS     = 4,
    parameter int  DATA_W        = udp_pp_pkg::DATA_W,
    parameter int  KEEP_W        = udp_pp_pkg::KEEP_W,
    parameter int  STALL_TIMEOUT = 64,
    localparam int IDX_W         = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS*DATA_W-1:0]   s_data,
    input  logic [NUM_PORTS*KEEP_W-1:0]   s_keep,
    input  logic [NUM_PORTS-1:0]          s_valid,
    input  logic [NUM_PORTS-1:0]          s_last,
    output logic [NUM_PORTS-1:0]          s_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic [KEEP_W-1:0]             m_keep,
    output logic                          m_valid,
    output logic                          m_last,
    input  logic                          m_ready,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          grant_active,
    output logic                          abort_pulse
`ifdef ARB_STATS_EN
    ,
    input  logic [IDX_W-1:0]              stat_sel,
    output logic [31:0]                   stat_pkts,
    output logic [31:0]                   stat_aborts
`endif
);
    import udp_pp_pkg::*;

    localparam int CNT_W = $clog2(STALL_TIMEOUT);

    arb_state_t           r_state;
    logic [IDX_W-1:0]     r_grant_id;
    logic [NUM_PORTS-1:0] r_grant_oh;
    logic                 r_grant_active;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [NUM_PORTS-1:0] r_drop;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic [NUM_PORTS-1:0] w_eligible;
    logic [NUM_PORTS-1:0] w_pick_oh;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_any;
    logic                 w_g_valid;
    logic                 w_g_last;
    logic                 w_beat_acc;
    logic                 w_abort;

    assign w_eligible = s_valid & ~r_drop;

    rr_arb_pick #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req       (w_eligible),
        .i_ptr       (r_rr_ptr),
        .o_grant_oh  (w_pick_oh),
        .o_grant_idx (w_pick_idx),
        .o_any       (w_pick_any)
    );

    assign w_g_valid  = s_valid[r_grant_id];
    assign w_g_last   = s_last[r_grant_id];
    assign w_beat_acc = (r_state == GRANTED) && w_g_valid && m_ready;
    // A beat arriving on the timeout cycle wins, so the abort needs the source idle.
    assign w_abort    = (r_state == GRANTED) && !w_g_valid &&
                        (r_stall_cnt == CNT_W'(STALL_TIMEOUT - 1));

    assign grant_id     = r_grant_id;
    assign grant_active = r_grant_active;
    assign abort_pulse  = w_abort;

    always_comb begin
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        m_keep  = '0;
        s_ready = r_drop;
        case (r_state)
            GRANTED: begin
                m_valid = w_g_valid;
                m_last  = w_g_last;
                m_data  = s_data[r_grant_id*DATA_W +: DATA_W];
                m_keep  = s_keep[r_grant_id*KEEP_W +: KEEP_W];
                s_ready = r_drop | (r_grant_oh & {NUM_PORTS{m_ready}});
            end
            ABORT: begin
                m_valid = 1'b1;
                m_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_grant_id     <= '0;
            r_grant_oh     <= '0;
            r_grant_active <= 1'b0;
            r_rr_ptr       <= IDX_W'(NUM_PORTS - 1);
            r_drop         <= '0;
            r_stall_cnt    <= '0;
        end else begin
            r_drop <= r_drop & ~(s_valid & s_last);
            case (r_state)
                IDLE: begin
                    r_stall_cnt <= '0;
                    if (w_pick_any) begin
                        r_grant_id     <= w_pick_idx;
                        r_grant_oh     <= w_pick_oh;
                        r_grant_active <= 1'b1;
                        r_state        <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (w_beat_acc) begin
                        r_stall_cnt <= '0;
                        if (w_g_last) begin
                            r_rr_ptr       <= r_grant_id;
                            r_grant_active <= 1'b0;
                            r_grant_oh     <= '0;
                            r_state        <= IDLE;
                        end
                    end else if (!w_g_valid) begin
                        if (w_abort) begin
                            r_stall_cnt        <= '0;
                            r_drop[r_grant_id] <= 1'b1;
                            r_state            <= ABORT;
                        end else begin
                            r_stall_cnt <= r_stall_cnt + 1'b1;
                        end
                    end
                end
                ABORT: begin
                    if (m_ready) begin
                        r_rr_ptr       <= r_grant_id;
                        r_grant_active <= 1'b0;
                        r_grant_oh     <= '0;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] r_pkt_cnt   [NUM_PORTS];
    logic [31:0] r_abort_cnt [NUM_PORTS];

    // Abort beats are never counted as packets; they only go through the ABORT state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_pkt_cnt[p]   <= '0;
                r_abort_cnt[p] <= '0;
            end
            stat_pkts   <= '0;
            stat_aborts <= '0;
        end else begin
            if (w_beat_acc && w_g_last) begin
                r_pkt_cnt[r_grant_id] <= r_pkt_cnt[r_grant_id] + 32'd1;
            end
            if (w_abort) begin
                r_abort_cnt[r_grant_id] <= r_abort_cnt[r_grant_id] + 32'd1;
            end
            stat_pkts   <= r_pkt_cnt[stat_sel];
            stat_aborts <= r_abort_cnt[stat_sel];
        end
    end
`endif
endmodule

// File: tb/tb_ingress_pkt_arbiter.sv
// Directed self-checking bench for ingress_pkt_arbiter (grant order, backpressure, stall abort, reset).
module tb_ingress_pkt_arbiter;
    localparam int NP = 4;
    localparam int DW = 256;
    localparam int KW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*DW-1:0]  s_data;
    logic [NP*KW-1:0]  s_keep;
    logic [NP-1:0]     s_valid;
    logic [NP-1:0]     s_last;
    logic [NP-1:0]     s_ready;
    logic [DW-1:0]     m_data;
    logic [KW-1:0]     m_keep;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;
    logic [1:0]        grant_id;
    logic              grant_active;
    logic              abort_pulse;
`ifdef ARB_STATS_EN
    logic [1:0]        stat_sel;
    logic [31:0]       stat_pkts;
    logic [31:0]       stat_aborts;
`endif

    int srcPkts   [NP];
    int srcLen    [NP];
    int srcBeat   [NP];
    int srcPktIdx [NP];
    bit srcHold   [NP];
    int numChecks = 0;
    int numFails  = 0;

    ingress_pkt_arbiter #(
        .NUM_PORTS     (NP),
        .DATA_W        (DW),
        .KEEP_W        (KW),
        .STALL_TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_keep       (s_keep),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_keep       (m_keep),
        .m_valid      (m_valid),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .abort_pulse  (abort_pulse)
`ifdef ARB_STATS_EN
        ,
        .stat_sel     (stat_sel),
        .stat_pkts    (stat_pkts),
        .stat_aborts  (stat_aborts)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] tagOf(input int p, input int pk, input int b);
        return DW'({8'(p), 8'(pk), 8'(b), 8'hC3});
    endfunction

    function automatic logic [KW-1:0] keepOf(input int p, input int b);
        return {8'hA0 + 8'(p), 8'(b), 16'h5A5A};
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        numChecks++;
        if (obs !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives every source's current beat onto the pins from the per-port source state.
    task automatic applyStimulus();
        for (int p = 0; p < NP; p++) begin
            s_valid[p]         = (srcPkts[p] > 0) && !srcHold[p];
            s_last[p]          = (srcBeat[p] == srcLen[p] - 1);
            s_data[p*DW +: DW] = tagOf(p, srcPktIdx[p], srcBeat[p]);
            s_keep[p*KW +: KW] = keepOf(p, srcBeat[p]);
        end
    endtask

    // Handshakes are captured mid-cycle, sources advance at the next negedge.
    task automatic nextCycle();
        logic [NP-1:0] fire;
        fire = s_valid & s_ready;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            if (fire[p]) begin
                if (s_last[p]) begin
                    srcBeat[p] = 0;
                    srcPkts[p]--;
                    srcPktIdx[p]++;
                end else begin
                    srcBeat[p]++;
                end
            end
        end
        applyStimulus();
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        for (int p = 0; p < NP; p++) begin
            srcPkts[p] = 0; srcLen[p] = 1; srcBeat[p] = 0; srcPktIdx[p] = 0; srcHold[p] = 1'b0;
        end
        applyStimulus();
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        m_ready = 1'b0;
        s_data  = '0;
        s_keep  = '0;
        s_valid = '0;
        s_last  = '0;
`ifdef ARB_STATS_EN
        stat_sel = 2'd0;
`endif
        for (int p = 0; p < NP; p++) begin
            srcPkts[p] = 0; srcLen[p] = 1; srcBeat[p] = 0; srcPktIdx[p] = 0; srcHold[p] = 1'b0;
        end
        applyStimulus();
        @(negedge clk);
        #1;
        nextCycle();
        checkOutput("rst_s_ready", DW'(s_ready), DW'(4'h0));
        checkOutput("rst_m_valid", DW'(m_valid), DW'(1'b0));
        checkOutput("rst_grant_active", DW'(grant_active), DW'(1'b0));
        checkOutput("rst_grant_id", DW'(grant_id), DW'(2'd0));
        checkOutput("rst_abort", DW'(abort_pulse), DW'(1'b0));
        rst_n = 1'b1;

        // Ports 0 and 2 with 3-beat packets: whole packet of 0, one idle cycle, then 2.
        srcLen[0] = 3; srcLen[2] = 3; srcPkts[0] = 1; srcPkts[2] = 1;
        m_ready = 1'b1;
        applyStimulus();
        #1;
        checkOutput("t1_arb_mvalid", DW'(m_valid), DW'(1'b0));
        for (int b = 0; b < 3; b++) begin
            nextCycle();
            checkOutput("t1_p0_gid", DW'(grant_id), DW'(2'd0));
            checkOutput("t1_p0_data", m_data, tagOf(0, 0, b));
            checkOutput("t1_p0_keep", DW'(m_keep), DW'(keepOf(0, b)));
            checkOutput("t1_p0_last", DW'(m_last), DW'(b == 2));
            checkOutput("t1_p2_blocked", DW'(s_ready[2]), DW'(1'b0));
        end
        nextCycle();
        checkOutput("t1_gap_mvalid", DW'(m_valid), DW'(1'b0));
        checkOutput("t1_gap_active", DW'(grant_active), DW'(1'b0));
        for (int b = 0; b < 3; b++) begin
            nextCycle();
            checkOutput("t1_p2_gid", DW'(grant_id), DW'(2'd2));
            checkOutput("t1_p2_data", m_data, tagOf(2, 0, b));
        end
        nextCycle();
        checkOutput("t1_end_mvalid", DW'(m_valid), DW'(1'b0));

        // All four ports with 1-beat packets: 0,1,2,3,0,1,2,3 with an arbitration cycle between.
        doReset();
        for (int p = 0; p < NP; p++) begin
            srcLen[p] = 1; srcPkts[p] = 2;
        end
        applyStimulus();
        #1;
        checkOutput("t2_arb_mvalid", DW'(m_valid), DW'(1'b0));
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            checkOutput("t2_gid", DW'(grant_id), DW'(i % 4));
            checkOutput("t2_mvalid", DW'(m_valid), DW'(1'b1));
            checkOutput("t2_data", m_data, tagOf(i % 4, i / 4, 0));
            nextCycle();
            checkOutput("t2_gap_mvalid", DW'(m_valid), DW'(1'b0));
        end

        // Port 1 held off by downstream for 200 cycles: no abort, packet intact.
        begin
            bit sawAbort;
            bit lostValid;
            sawAbort  = 1'b0;
            lostValid = 1'b0;
            srcLen[1] = 2; srcPkts[1] = 1;
            m_ready   = 1'b0;
            applyStimulus();
            nextCycle();
            checkOutput("t3_gid", DW'(grant_id), DW'(2'd1));
            for (int i = 0; i < 200; i++) begin
                if (abort_pulse) sawAbort = 1'b1;
                if (!m_valid) lostValid = 1'b1;
                nextCycle();
            end
            checkOutput("t3_no_abort", DW'(sawAbort), DW'(1'b0));
            checkOutput("t3_valid_held", DW'(lostValid), DW'(1'b0));
            m_ready = 1'b1;
            #1;
            checkOutput("t3_beat0", m_data, tagOf(1, 2, 0));
            nextCycle();
            checkOutput("t3_beat1", m_data, tagOf(1, 2, 1));
            checkOutput("t3_last", DW'(m_last), DW'(1'b1));
            nextCycle();
            checkOutput("t3_end_mvalid", DW'(m_valid), DW'(1'b0));
        end

        // Port 1 stalls after its first beat: abort on idle cycle 64, tail flushed while port 3 runs.
        srcLen[1] = 3; srcPkts[1] = 1;
        applyStimulus();
        nextCycle();
        checkOutput("t4_gid", DW'(grant_id), DW'(2'd1));
        checkOutput("t4_beat0", m_data, tagOf(1, 3, 0));
        srcHold[1] = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            nextCycle();
            checkOutput($sformatf("t4_abort_k%0d", k), DW'(abort_pulse), DW'(k == 64));
        end
        checkOutput("t4_idle_mvalid", DW'(m_valid), DW'(1'b0));
        nextCycle();
        checkOutput("t4_abt_mvalid", DW'(m_valid), DW'(1'b1));
        checkOutput("t4_abt_last", DW'(m_last), DW'(1'b1));
        checkOutput("t4_abt_keep", DW'(m_keep), DW'(32'h0));
        checkOutput("t4_abt_data", m_data, DW'(1'b0));
        checkOutput("t4_abt_pulse", DW'(abort_pulse), DW'(1'b0));
        checkOutput("t4_abt_flush_rdy", DW'(s_ready[1]), DW'(1'b1));
        srcHold[1] = 1'b0;
        srcLen[3]  = 2; srcPkts[3] = 1;
        nextCycle();
        checkOutput("t4_arb_mvalid", DW'(m_valid), DW'(1'b0));
        checkOutput("t4_flush1_rdy", DW'(s_ready[1]), DW'(1'b1));
        nextCycle();
        checkOutput("t4_p3_gid", DW'(grant_id), DW'(2'd3));
        checkOutput("t4_p3_beat0", m_data, tagOf(3, 2, 0));
        checkOutput("t4_flush2_rdy", DW'(s_ready[1]), DW'(1'b1));
        nextCycle();
        checkOutput("t4_p3_beat1", m_data, tagOf(3, 2, 1));
        checkOutput("t4_p3_last", DW'(m_last), DW'(1'b1));
        checkOutput("t4_drop_cleared", DW'(s_ready[1]), DW'(1'b0));
        nextCycle();
        checkOutput("t4_end_active", DW'(grant_active), DW'(1'b0));

        // Reset in the middle of a port 2 packet, then port 0 wins against port 2.
        srcLen[2] = 4; srcPkts[2] = 1;
        applyStimulus();
        nextCycle();
        checkOutput("t5_gid", DW'(grant_id), DW'(2'd2));
        nextCycle();
        checkOutput("t5_beat1", m_data, tagOf(2, 2, 1));
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_mvalid", DW'(m_valid), DW'(1'b0));
        checkOutput("t5_rst_active", DW'(grant_active), DW'(1'b0));
        checkOutput("t5_rst_gid", DW'(grant_id), DW'(2'd0));
        checkOutput("t5_rst_sready", DW'(s_ready), DW'(4'h0));
        checkOutput("t5_rst_mdata", m_data, DW'(1'b0));
        doReset();
        srcLen[0] = 1; srcLen[2] = 1; srcPkts[0] = 1; srcPkts[2] = 1;
        applyStimulus();
        #1;
        checkOutput("t5_arb_mvalid", DW'(m_valid), DW'(1'b0));
        nextCycle();
        checkOutput("t5_first_gid", DW'(grant_id), DW'(2'd0));
        checkOutput("t5_first_data", m_data, tagOf(0, 0, 0));
        nextCycle();
        nextCycle();
        checkOutput("t5_second_gid", DW'(grant_id), DW'(2'd2));
        nextCycle();

`ifdef ARB_STATS_EN
        // Five good packets and one abort on port 3, then read its counters.
        begin
            bit sawAbort;
            sawAbort  = 1'b0;
            srcLen[3] = 1; srcPkts[3] = 5;
            repeat (12) nextCycle();
            srcLen[3] = 2; srcPkts[3] = 1;
            nextCycle();
            nextCycle();
            srcHold[3] = 1'b1;
            for (int i = 0; i < 100 && !sawAbort; i++) begin
                if (abort_pulse) sawAbort = 1'b1;
                else nextCycle();
            end
            checkOutput("st_abort_seen", DW'(sawAbort), DW'(1'b1));
            nextCycle();
            nextCycle();
            stat_sel = 2'd3;
            nextCycle();
            checkOutput("st_pkts", DW'(stat_pkts), DW'(32'd5));
            checkOutput("st_aborts", DW'(stat_aborts), DW'(32'd1));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule
